// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access pipeline stage: funct3 encodings,
// FSM state type and the store lane/strobe generator.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } store_lanes_t;

    // Replicate store data across lanes and shift the strobe to the byte offset;
    // loads never assert a strobe.
    function automatic store_lanes_t store_lanes(input logic [2:0]  funct3,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] data,
                                                 input logic        is_store);
        store_lanes_t s;
        s.wdata = data;
        s.wstrb = 4'b0000;
        if (is_store) begin
            case (funct3)
                F3_B: begin
                    s.wdata = {4{data[7:0]}};
                    s.wstrb = 4'b0001 << off;
                end
                F3_H: begin
                    s.wdata = {2{data[15:0]}};
                    s.wstrb = 4'b0011 << off;
                end
                F3_W: begin
                    s.wdata = data;
                    s.wstrb = 4'b1111;
                end
                default: begin
                    s.wdata = data;
                    s.wstrb = 4'b0000;
                end
            endcase
        end else begin
            s.wstrb = 4'b0000;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data aligner: picks the addressed byte/halfword out of the read word
// and sign- or zero-extends it according to funct3.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection by byte offset
    always_comb begin
        byte_s = 8'h00;
        case (offset)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (offset[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extension by access type
    always_comb begin
        data = 32'h0000_0000;
        case (funct3)
            F3_B:    data = {{24{byte_s[7]}}, byte_s};
            F3_H:    data = {{16{half_s[15]}}, half_s};
            F3_W:    data = rdata;
            F3_BU:   data = {24'h00_0000, byte_s};
            F3_HU:   data = {16'h0000, half_s};
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory-access stage: issues loads/stores over a req/ready handshake,
// stalls upstream while an access is outstanding and owns the MEM/WB register.
module mem_stage
    import mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_alu_result,
    input  logic [XLEN-1:0]   ex_rs2_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [2:0]        ex_funct3,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_wb_select,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ready,
    output logic              wb_valid,
    output logic [XLEN-1:0]   alu_result,
    output logic [XLEN-1:0]   mem_rdata,
    output logic              wb_select,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_reg_write,
    output logic              mem_fault
);

    mem_state_t        state_r;
    mem_state_t        state_nxt_s;
    logic              mem_op_s;
    logic              f3_legal_s;
    logic              misaligned_s;
    logic              fault_s;
    logic              launch_s;
    store_lanes_t      lanes_s;
    logic [XLEN-1:0]   load_data_s;

    logic              req_r;
    logic              we_r;
    logic [XLEN-1:0]   addr_r;
    logic [XLEN-1:0]   eaddr_r;
    logic [XLEN-1:0]   wdata_r;
    logic [3:0]        wstrb_r;
    logic [1:0]        off_r;
    logic [2:0]        f3_r;
    logic [REG_AW-1:0] rd_r;
    logic              rw_r;
    logic              sel_r;

    assign mem_op_s = ex_valid & (ex_mem_read | ex_mem_write);
    assign lanes_s  = store_lanes(ex_funct3, ex_alu_result[1:0], ex_rs2_data, ex_mem_write);

    // Fault classification: illegal funct3 for the direction, misalignment, or read+write together
    always_comb begin
        f3_legal_s   = 1'b0;
        misaligned_s = 1'b0;
        case (ex_funct3)
            F3_B:    f3_legal_s = 1'b1;
            F3_H: begin
                f3_legal_s   = 1'b1;
                misaligned_s = ex_alu_result[0];
            end
            F3_W: begin
                f3_legal_s   = 1'b1;
                misaligned_s = |ex_alu_result[1:0];
            end
            F3_BU:   f3_legal_s = ex_mem_read & ~ex_mem_write;
            F3_HU: begin
                f3_legal_s   = ex_mem_read & ~ex_mem_write;
                misaligned_s = ex_alu_result[0];
            end
            default: f3_legal_s = 1'b0;
        endcase
        fault_s  = mem_op_s & ((ex_mem_read & ex_mem_write) | ~f3_legal_s | misaligned_s);
        launch_s = mem_op_s & ~fault_s;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (dmem_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: stall drops in the completing ACCESS cycle so upstream advances on that edge
    always_comb begin
        stall = 1'b0;
        case (state_r)
            IDLE:    stall = launch_s;
            ACCESS:  stall = ~dmem_ready;
            default: stall = 1'b0;
        endcase
    end

    // Request registers: captured on launch, held stable until the access completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= {XLEN{1'b0}};
            eaddr_r <= {XLEN{1'b0}};
            wdata_r <= {XLEN{1'b0}};
            wstrb_r <= 4'b0000;
            off_r   <= 2'b00;
            f3_r    <= 3'b000;
            rd_r    <= {REG_AW{1'b0}};
            rw_r    <= 1'b0;
            sel_r   <= 1'b0;
        end else if ((state_r == IDLE) && launch_s) begin
            req_r   <= 1'b1;
            we_r    <= ex_mem_write;
            addr_r  <= {ex_alu_result[XLEN-1:2], 2'b00};
            eaddr_r <= ex_alu_result;
            wdata_r <= lanes_s.wdata;
            wstrb_r <= lanes_s.wstrb;
            off_r   <= ex_alu_result[1:0];
            f3_r    <= ex_funct3;
            rd_r    <= ex_rd;
            rw_r    <= ex_reg_write;
            sel_r   <= ex_wb_select;
        end else if ((state_r == ACCESS) && dmem_ready) begin
            req_r   <= 1'b0;
        end else begin
            req_r   <= req_r;
        end
    end

    assign dmem_req   = req_r;
    assign dmem_we    = we_r;
    assign dmem_addr  = addr_r;
    assign dmem_wdata = wdata_r;
    assign dmem_wstrb = wstrb_r;

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (off_r),
        .funct3 (f3_r),
        .data   (load_data_s)
    );

    // MEM/WB register: retire from ACCESS on ready, or directly from IDLE for non-launching ops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            alu_result   <= {XLEN{1'b0}};
            mem_rdata    <= {XLEN{1'b0}};
            wb_select    <= 1'b0;
            wb_rd        <= {REG_AW{1'b0}};
            wb_reg_write <= 1'b0;
            mem_fault    <= 1'b0;
        end else if ((state_r == ACCESS) && dmem_ready) begin
            wb_valid     <= 1'b1;
            alu_result   <= eaddr_r;
            mem_rdata    <= we_r ? {XLEN{1'b0}} : load_data_s;
            wb_select    <= sel_r;
            wb_rd        <= rd_r;
            wb_reg_write <= rw_r;
            mem_fault    <= 1'b0;
        end else if ((state_r == IDLE) && ex_valid && !launch_s) begin
            wb_valid     <= 1'b1;
            alu_result   <= ex_alu_result;
            mem_rdata    <= {XLEN{1'b0}};
            wb_select    <= ex_wb_select;
            wb_rd        <= ex_rd;
            wb_reg_write <= ex_reg_write & ~fault_s;
            mem_fault    <= fault_s;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            mem_fault    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written corner
// sequences and randomized ops checked against a behavioural reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rs2_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_wb_select;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        wb_valid;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic        wb_select;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        mem_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_rs2_data(ex_rs2_data), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_wb_select(ex_wb_select), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .wb_valid(wb_valid),
        .alu_result(alu_result), .mem_rdata(mem_rdata), .wb_select(wb_select),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .mem_fault(mem_fault)
    );

    typedef struct {
        logic        valid, mr, mw;
        logic [2:0]  f3;
        logic [31:0] addr, rs2;
        logic [4:0]  rd;
        logic        rw, sel;
        int          waits;
        logic [31:0] rword;
        int          e_cycles;
        logic        e_req, e_fault, e_we, e_rw, e_chk;
        logic [31:0] e_daddr, e_wdata, e_rdata;
        logic [3:0]  e_wstrb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic valid, input logic mr, input logic mw,
                                input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] rs2, input logic [4:0] rd,
                                input logic rw, input logic sel, input int waits,
                                input logic [31:0] rword);
        vec_t v;
        v = '{default: '0};
        v.valid = valid; v.mr = mr; v.mw = mw; v.f3 = f3; v.addr = addr; v.rs2 = rs2;
        v.rd = rd; v.rw = rw; v.sel = sel; v.waits = waits; v.rword = rword;
        return v;
    endfunction

    function automatic vec_t xp(input vec_t v, input int cycles, input logic req,
                                input logic fault, input logic we, input logic rw,
                                input logic chk_rd, input logic [31:0] daddr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input logic [31:0] rdata);
        vec_t r = v;
        r.e_cycles = cycles; r.e_req = req; r.e_fault = fault; r.e_we = we; r.e_rw = rw;
        r.e_chk = chk_rd; r.e_daddr = daddr; r.e_wdata = wdata; r.e_wstrb = wstrb;
        r.e_rdata = rdata;
        return r;
    endfunction

    // Reference model: derives expectations from access size, offset and legality rules
    function automatic vec_t model(input vec_t v);
        vec_t        r = v;
        int          size, off;
        logic [63:0] mask, val;
        bit          is_mem, legal, fault;
        is_mem = v.valid && (v.mr || v.mw);
        size   = 1 << (v.f3 % 4);
        off    = v.addr % 4;
        if (v.mr && v.mw)  legal = 0;
        else if (v.mr)     legal = v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        else               legal = v.f3 inside {3'd0, 3'd1, 3'd2};
        fault = is_mem && (!legal || (v.addr % size) != 0);
        r.e_req    = is_mem && !fault;
        r.e_cycles = r.e_req ? 2 + v.waits : 1;
        r.e_fault  = fault;
        r.e_rw     = v.rw && !fault;
        r.e_we     = v.mw;
        r.e_chk    = r.e_req;
        r.e_daddr  = v.addr - off;
        mask = (64'd1 << (8 * size)) - 64'd1;
        if (v.mw) begin
            if (size == 1)      r.e_wdata = (v.rs2 & 32'hFF) * 32'h0101_0101;
            else if (size == 2) r.e_wdata = (v.rs2 & 32'hFFFF) * 32'h0001_0001;
            else                r.e_wdata = v.rs2;
            r.e_wstrb = 4'(((1 << size) - 1) << off);
            r.e_rdata = 32'd0;
        end else begin
            val = ({32'd0, v.rword} >> (8 * off)) & mask;
            if (v.f3 < 3'd4 && val[8 * size - 1]) val = val | ~mask;
            r.e_rdata = val[31:0];
            r.e_wdata = 32'd0;
            r.e_wstrb = 4'd0;
        end
        return r;
    endfunction

    // Drive one op at a negedge, act as memory, run until stall drops, then check MEM/WB
    task automatic apply_vec(input vec_t v, input string tag);
        int          cycles, stalls, w;
        bit          saw_req, stable, done;
        logic [31:0] a0, d0;
        logic [3:0]  s0;
        logic        we0;
        ex_valid = v.valid; ex_mem_read = v.mr; ex_mem_write = v.mw; ex_funct3 = v.f3;
        ex_alu_result = v.addr; ex_rs2_data = v.rs2; ex_rd = v.rd; ex_reg_write = v.rw;
        ex_wb_select = v.sel; dmem_rdata = v.rword; dmem_ready = 1'b0;
        cycles = 0; stalls = 0; w = 0; saw_req = 0; stable = 1; done = 0;
        a0 = '0; d0 = '0; s0 = '0; we0 = 1'b0;
        while (!done && cycles < 40) begin
            #1;
            if (dmem_req === 1'b1) begin
                if (!saw_req) begin
                    a0 = dmem_addr; d0 = dmem_wdata; s0 = dmem_wstrb; we0 = dmem_we; saw_req = 1;
                end else if (dmem_addr !== a0 || dmem_wdata !== d0 || dmem_wstrb !== s0 || dmem_we !== we0) begin
                    stable = 0;
                end
                dmem_ready = (w == v.waits);
                w++;
            end
            #1;
            if (stall === 1'b1) stalls++;
            cycles++;
            if (stall !== 1'b1) done = 1;
            @(posedge clk);
            @(negedge clk);
            dmem_ready = 1'b0;
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " cycles"}, cycles, v.e_cycles);
        chk({tag, " stalls"}, stalls, v.e_cycles - 1);
        chk({tag, " req"}, 32'(saw_req), 32'(v.e_req));
        if (v.e_req) begin
            chk({tag, " addr"}, a0, v.e_daddr);
            chk({tag, " we"}, 32'(we0), 32'(v.e_we));
            chk({tag, " wstrb"}, 32'(s0), 32'(v.e_wstrb));
            chk({tag, " stable"}, 32'(stable), 32'd1);
            if (v.e_we) chk({tag, " wdata"}, d0, v.e_wdata);
        end
        chk({tag, " wb_valid"}, 32'(wb_valid), 32'(v.valid));
        if (v.valid) begin
            chk({tag, " reg_write"}, 32'(wb_reg_write), 32'(v.e_rw));
            chk({tag, " fault"}, 32'(mem_fault), 32'(v.e_fault));
            chk({tag, " alu_result"}, alu_result, v.addr);
            chk({tag, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
            chk({tag, " wb_select"}, 32'(wb_select), 32'(v.sel));
            if (v.e_chk) chk({tag, " mem_rdata"}, mem_rdata, v.e_rdata);
        end else begin
            chk({tag, " reg_write"}, 32'(wb_reg_write), 32'd0);
            chk({tag, " fault"}, 32'(mem_fault), 32'd0);
        end
    endtask

    // One bubble cycle: nothing retires, so the fault pulse must be gone
    task automatic idle(input string tag);
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " idle wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, " idle fault"}, 32'(mem_fault), 32'd0);
        chk({tag, " idle reg_write"}, 32'(wb_reg_write), 32'd0);
    endtask

    vec_t tbl[15];
    vec_t v;

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_alu_result = '0; ex_rs2_data = '0; ex_mem_read = 1'b0;
        ex_mem_write = 1'b0; ex_funct3 = '0; ex_rd = '0; ex_reg_write = 1'b0;
        ex_wb_select = 1'b0; dmem_rdata = '0; dmem_ready = 1'b0;

        tbl[0]  = xp(mk(1,0,0,3'd0,32'h0000_1234,32'h0,5'd5,1,0,0,32'h0), 1,0,0,0,1,0, 32'h0,32'h0,4'h0,32'h0);
        tbl[1]  = xp(mk(1,1,0,3'd0,32'h0000_0103,32'h0,5'd7,1,1,3,32'h80AA_BBCC), 5,1,0,0,1,1, 32'h100,32'h0,4'h0,32'hFFFF_FF80);
        tbl[2]  = xp(mk(1,1,0,3'd4,32'h0000_0103,32'h0,5'd7,1,1,3,32'h80AA_BBCC), 5,1,0,0,1,1, 32'h100,32'h0,4'h0,32'h0000_0080);
        tbl[3]  = xp(mk(1,0,1,3'd1,32'h0000_0202,32'h1234_ABCD,5'd0,0,0,0,32'h0), 2,1,0,1,0,1, 32'h200,32'hABCD_ABCD,4'b1100,32'h0);
        tbl[4]  = xp(mk(1,1,0,3'd2,32'h0000_0301,32'h0,5'd9,1,1,0,32'h1111_1111), 1,0,1,0,0,0, 32'h0,32'h0,4'h0,32'h0);
        tbl[5]  = xp(mk(1,1,0,3'd3,32'h0000_0300,32'h0,5'd9,1,1,0,32'h1111_1111), 1,0,1,0,0,0, 32'h0,32'h0,4'h0,32'h0);
        tbl[6]  = xp(mk(1,1,0,3'd1,32'h0000_0102,32'h0,5'd3,1,1,1,32'h80AA_BBCC), 3,1,0,0,1,1, 32'h100,32'h0,4'h0,32'hFFFF_80AA);
        tbl[7]  = xp(mk(1,1,0,3'd5,32'h0000_0100,32'h0,5'd4,1,1,0,32'h80AA_BBCC), 2,1,0,0,1,1, 32'h100,32'h0,4'h0,32'h0000_BBCC);
        tbl[8]  = xp(mk(1,0,1,3'd0,32'h0000_0201,32'h0000_00A5,5'd0,0,0,2,32'h0), 4,1,0,1,0,1, 32'h200,32'hA5A5_A5A5,4'b0010,32'h0);
        tbl[9]  = xp(mk(1,0,1,3'd2,32'h0000_0204,32'hCAFE_F00D,5'd0,0,0,0,32'h0), 2,1,0,1,0,1, 32'h204,32'hCAFE_F00D,4'b1111,32'h0);
        tbl[10] = xp(mk(1,1,1,3'd2,32'h0000_0400,32'h0,5'd6,1,1,0,32'h0), 1,0,1,0,0,0, 32'h0,32'h0,4'h0,32'h0);
        tbl[11] = xp(mk(1,0,1,3'd4,32'h0000_0400,32'h0,5'd6,1,0,0,32'h0), 1,0,1,0,0,0, 32'h0,32'h0,4'h0,32'h0);
        tbl[12] = xp(mk(1,1,0,3'd1,32'h0000_0101,32'h0,5'd6,1,1,0,32'h0), 1,0,1,0,0,0, 32'h0,32'h0,4'h0,32'h0);
        tbl[13] = xp(mk(1,1,0,3'd2,32'h0000_0400,32'h0,5'd8,1,1,1,32'hDEAD_BEEF), 3,1,0,0,1,1, 32'h400,32'h0,4'h0,32'hDEAD_BEEF);
        tbl[14] = xp(mk(0,1,0,3'd2,32'h0000_0500,32'h0,5'd8,1,1,0,32'h0), 1,0,0,0,0,0, 32'h0,32'h0,4'h0,32'h0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset dmem_req", 32'(dmem_req), 32'd0);
        chk("reset wb_valid", 32'(wb_valid), 32'd0);
        chk("reset reg_write", 32'(wb_reg_write), 32'd0);
        chk("reset fault", 32'(mem_fault), 32'd0);
        chk("reset alu_result", alu_result, 32'd0);
        chk("reset mem_rdata", mem_rdata, 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            apply_vec(tbl[i], $sformatf("vec%0d", i));
            idle($sformatf("vec%0d", i));
        end

        // Back-to-back: load then ALU op with no bubble
        apply_vec(tbl[13], "b2b load");
        apply_vec(xp(mk(1,0,0,3'd0,32'h0000_0055,32'h0,5'd2,1,0,0,32'h0), 1,0,0,0,1,0,
                     32'h0,32'h0,4'h0,32'h0), "b2b alu");
        idle("b2b");

        // Reset in the middle of an access
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'd2;
        ex_alu_result = 32'h0000_0400; ex_reg_write = 1'b1; dmem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("midrst req before", 32'(dmem_req), 32'd1);
        ex_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst req", 32'(dmem_req), 32'd0);
        chk("midrst wb_valid", 32'(wb_valid), 32'd0);
        chk("midrst stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dmem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("midrst no retire", 32'(wb_valid), 32'd0);
            chk("midrst req after", 32'(dmem_req), 32'd0);
        end
        dmem_ready = 1'b0;
        @(negedge clk);

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            int kind;
            v = mk(($urandom_range(0, 9) != 0), 0, 0, 3'd0, $urandom & 32'h0000_0FFF,
                   $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), $urandom);
            kind = $urandom_range(0, 7);
            v.mr = (kind inside {1, 2, 3, 7});
            v.mw = (kind inside {4, 5, 7});
            v.f3 = 3'($urandom_range(0, 7));
            v = model(v);
            apply_vec(v, $sformatf("rand%0d", i));
            if ($urandom_range(0, 2) == 0) idle($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline memory-access stage between execute and write-back; owns the MEM/WB pipeline register.
- Issues loads/stores to the data memory over a req/ready handshake and stalls upstream while an access is outstanding.
- Aligns and sign/zero-extends load data; drives the write-back stage's alu_result, mem_rdata and wb_select inputs directly.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_AW, 5, register-file index width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_alu_result  in  XLEN  effective address (memory ops) or ALU result
- ex_rs2_data  in  XLEN  store data
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_funct3  in  3  access size/sign
- ex_rd  in  REG_AW  destination register
- ex_reg_write  in  1  writes register file
- ex_wb_select  in  1  0: ALU result, 1: memory data
- stall  out  1  upstream must hold EX/MEM contents
- dmem_req  out  1  access request
- dmem_we  out  1  1: store
- dmem_addr  out  XLEN  word address, bits [1:0] = 0
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_wstrb  out  4  byte enables
- dmem_rdata  in  XLEN  read word, valid when dmem_ready=1
- dmem_ready  in  1  access completes this cycle
- wb_valid  out  1  MEM/WB holds a valid instruction
- alu_result  out  XLEN  registered ALU result
- mem_rdata  out  XLEN  registered, aligned and extended load data
- wb_select  out  1  registered select
- wb_rd  out  REG_AW  registered destination
- wb_reg_write  out  1  registered write enable; forced 0 on fault
- mem_fault  out  1  registered, one-cycle pulse: misaligned access or illegal funct3

Behaviour:
- Reset (async, immediate): state=IDLE; dmem_req=0; all wb_* outputs, alu_result, mem_rdata and mem_fault =0. Any in-flight response is discarded.
- Memory op: mem_op = ex_valid & (ex_mem_read | ex_mem_write).
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other value is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- FSM, state IDLE:
  - Non-memory op, faulting op, or ex_valid=0: stall=0. MEM/WB loads at the next edge with wb_valid=ex_valid; latency 1 cycle.
  - Faulting op: no dmem access; wb_reg_write=0; mem_fault=1.
  - Legal memory op: stall=1 (combinational). At the edge, latch the request registers and byte offset, and go to ACCESS.
- FSM, state ACCESS:
  - dmem_req=1, driven from a register; addr/we/wdata/wstrb stay stable until ready.
  - dmem_ready=0: stall=1, hold.
  - dmem_ready=1: stall=0, so upstream advances at this edge. At the edge, MEM/WB loads (mem_rdata from load_align), wb_valid=1, state goes to IDLE.
  - Minimum memory-op occupancy is 2 cycles; each extra wait cycle adds one.
- MEM/WB register when no instruction retires: wb_valid=0, wb_reg_write=0, mem_fault=0; other fields hold.
- Store lanes:
  - SB: wdata={4{rs2[7:0]}}, wstrb=0001<<off.
  - SH: wdata={2{rs2[15:0]}}, wstrb=0011<<off.
  - SW: wdata=rs2, wstrb=1111.
  - Loads: wstrb=0000.
- Load extract: byte = rdata[8*off+:8], half = rdata[16*off[1]+:16]. Sign-extend for LB/LH, zero-extend for LBU/LHU, LW passes through.
- Stores retire with mem_rdata=0.
- mem_read and mem_write both set: treated as illegal (fault).
- dmem_ready while IDLE: ignored.

Decomposition:
- Shared package mem_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum mem_state_t {IDLE, ACCESS}.
  - Store-strobe/lane helper function.
- Sub-module load_align: combinational; inputs rdata, offset, funct3; output extended word.

Test Plan:
- Reset mid-ACCESS (dmem_req=1) → dmem_req=0 immediately, wb_valid=0, state IDLE; a later dmem_ready=1 causes no retire.
- Non-memory op alu_result=0x0000_1234, rd=5, reg_write=1 → next cycle wb_valid=1, alu_result=0x1234, wb_rd=5; stall never asserted.
- LB addr 0x103, dmem_rdata 0x80AA_BBCC, ready after 3 wait cycles → stall high 4 cycles, dmem_addr=0x100, mem_rdata=0xFFFF_FF80. Repeat with LBU → 0x0000_0080.
- SH addr 0x202, rs2=0x1234_ABCD, ready in first ACCESS cycle → dmem_we=1, wdata=0xABCD_ABCD, wstrb=1100, retire after 2 cycles.
- LW addr 0x301 → no dmem_req, mem_fault=1 for one cycle, wb_reg_write=0, wb_valid=1; funct3=011 load → same response.
- Back-to-back LW 0x400 (rdata 0xDEAD_BEEF), then ALU op 0x55 → retire in order: mem_rdata=0xDEAD_BEEF, then alu_result=0x55 one cycle later; the second op is not lost while stalled.
